axi4_slave_mem: RTL and testbench

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

---
 rtl/axi4_slave_mem.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: INCR bursts of 32-bit beats with independent read and
// write channels, plus a backdoor port for preloading and inspecting contents.
module axi4_slave_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // write address channel
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // read address channel
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // backdoor port
  input  logic        bd_we,
  input  logic [31:0] bd_addr,
  input  logic [31:0] bd_wdata,
  input  logic [3:0]  bd_wstrb,
  output logic [31:0] bd_rdata
);

  localparam int          AW          = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Full 32-bit word index; anything at or above MEM_WORDS is out of range,
  // including addresses below BASE_ADDR, which wrap to huge values.
  function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
    return (byte_addr - BASE_ADDR) >> 2;
  endfunction

  logic [31:0] r_mem [MEM_WORDS];

  // write channel state
  w_state_t    r_wstate;
  logic        r_awready, r_wready, r_bvalid, r_werr;
  logic [1:0]  r_bresp;
  logic [31:0] r_widx;
  logic [7:0]  r_wlen, r_wbeat;

  // read channel state
  r_state_t    r_rstate;
  logic        r_arready, r_rvalid, r_rlast;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata, r_ridx;
  logic [7:0]  r_rlen, r_rbeat;

  logic [31:0] r_bd_rdata;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic        w_w_last_beat, w_w_in_range, w_w_err, w_axi_we;
  logic [31:0] w_rd_idx, w_rd_word;
  logic        w_rd_ok;
  logic [31:0] w_bd_idx;
  logic        w_bd_ok, w_bd_we;

  assign w_aw_hs = awvalid && r_awready;
  assign w_w_hs  = wvalid && r_wready;
  assign w_ar_hs = arvalid && r_arready;
  assign w_r_hs  = r_rvalid && rready;

  // The burst ends on the beat count; wlast is only cross-checked.
  assign w_w_last_beat = (r_wbeat == r_wlen);
  assign w_w_in_range  = (r_widx < MEM_WORDS_W);
  assign w_w_err       = (wlast != w_w_last_beat) || !w_w_in_range;
  assign w_axi_we      = w_w_hs && w_w_in_range;

  // Index of the beat to present next: burst start from AR in idle,
  // otherwise the beat after the one currently on the bus.
  assign w_rd_idx  = (r_rstate == R_IDLE) ? word_idx(araddr) : r_ridx + 32'd1;
  assign w_rd_ok   = (w_rd_idx < MEM_WORDS_W);
  assign w_rd_word = w_rd_ok ? r_mem[w_rd_idx[AW-1:0]] : 32'hFFFF_FFFF;

  // Backdoor is frozen during reset and yields the whole word to a
  // concurrent AXI write of the same word.
  assign w_bd_idx = word_idx(bd_addr);
  assign w_bd_ok  = (w_bd_idx < MEM_WORDS_W);
  assign w_bd_we  = bd_we && rst && w_bd_ok && !(w_axi_we && (w_bd_idx == r_widx));

  // Storage: backdoor bytes first, AXI bytes second so AXI has the last word.
  // NOTE: the memory array has no reset; contents must survive rst and a
  // reset port on a RAM would prevent mapping it to block memory.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_bd_we && bd_wstrb[b]) r_mem[w_bd_idx[AW-1:0]][8*b +: 8] <= bd_wdata[8*b +: 8];
      if (w_axi_we && wstrb[b])   r_mem[r_widx[AW-1:0]][8*b +: 8]   <= wdata[8*b +: 8];
    end
  end

  // Write FSM: AW accept, count beats, then hold the response until bready.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_werr    <= 1'b0;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_widx    <= word_idx(awaddr);
            r_wlen    <= awlen;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            if (w_w_last_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || w_w_err) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_werr  <= r_werr || w_w_err;
              r_widx  <= r_widx + 32'd1;
              r_wbeat <= r_wbeat + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: beat 0 follows the AR handshake by one cycle; each R
  // handshake loads the next beat, and the beat is held while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_ridx    <= w_rd_idx;
            r_rlen    <= arlen;
            r_rbeat   <= '0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_word;
            r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rlast   <= (arlen == 8'd0);
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_ridx  <= w_rd_idx;
              r_rbeat <= r_rbeat + 8'd1;
              r_rdata <= w_rd_word;
              r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
              r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
            end
          end
        end
      endcase
    end
  end

  // Registered backdoor read of the word at bd_addr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bd_rdata <= '0;
    else      r_bd_rdata <= w_bd_ok ? r_mem[w_bd_idx[AW-1:0]] : 32'h0;
  end

  assign awready  = r_awready;
  assign wready   = r_wready;
  assign bvalid   = r_bvalid;
  assign bresp    = r_bresp;
  assign arready  = r_arready;
  assign rvalid   = r_rvalid;
  assign rlast    = r_rlast;
  assign rresp    = r_rresp;
  assign rdata    = r_rdata;
  assign bd_rdata = r_bd_rdata;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: directed corner cases, a table of
// write bursts, and random bursts compared against a word-array model.
module tb_axi4_slave_mem;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          MW   = 64;

  logic        clk, rst;
  logic [31:0] awaddr;  logic [7:0] awlen;  logic awvalid, awready;
  logic [31:0] wdata;   logic [3:0] wstrb;  logic wlast, wvalid, wready;
  logic [1:0]  bresp;   logic bvalid, bready;
  logic [31:0] araddr;  logic [7:0] arlen;  logic arvalid, arready;
  logic [31:0] rdata;   logic [1:0] rresp;  logic rlast, rvalid, rready;
  logic        bd_we;   logic [31:0] bd_addr, bd_wdata, bd_rdata; logic [3:0] bd_wstrb;

  axi4_slave_mem #(.BASE_ADDR(BASE), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_wstrb(bd_wstrb),
    .bd_rdata(bd_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [MW];
  logic [31:0] wbuf    [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  strb;
    int          bad_last;   // beat whose wlast is inverted, -1 for none
    logic [1:0]  exp_bresp;
  } wvec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] widx(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  function automatic void model_bytes(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input logic [3:0] strb, input int bad_last);
    logic err = 1'b0;
    for (int k = 0; k <= len; k++) begin
      logic [31:0] idx = widx(addr) + 32'(k);
      if (idx < MW) model_bytes(int'(idx), wbuf[k], strb);
      else          err = 1'b1;
      if (k == bad_last) err = 1'b1;
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic compare_read(input string name, input logic [31:0] addr, input int len);
    for (int k = 0; k <= len; k++) begin
      logic [31:0] idx = widx(addr) + 32'(k);
      logic [31:0] ed  = (idx < MW) ? ref_mem[int'(idx)] : 32'hFFFF_FFFF;
      logic [1:0]  er  = (idx < MW) ? 2'b00 : 2'b10;
      check($sformatf("%s beat%0d rdata", name, k), rd_data[k], ed);
      check($sformatf("%s beat%0d rresp", name, k), rd_resp[k], er);
      check($sformatf("%s beat%0d rlast", name, k), rd_last[k], k == len);
    end
  endtask

  // ---------------- bus tasks ----------------
  task automatic bd_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d; bd_wstrb = s;
    tick;
    bd_we = 1'b0;
    model_bytes(int'(widx(a)), d, s);
  endtask

  task automatic bd_read(input logic [31:0] a, output logic [31:0] d);
    bd_addr = a;
    tick;
    d = bd_rdata;
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] strb,
                           input int bad_last, output logic [1:0] resp);
    int n;
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1; n = 0;
    while (!awready && n < 50) begin tick; n++; end
    if (!awready) timeout_fail("awready");
    tick;
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      wdata = wbuf[k]; wstrb = strb; wlast = (k == len) ^ (k == bad_last); wvalid = 1'b1; n = 0;
      while (!wready && n < 50) begin tick; n++; end
      if (!wready) timeout_fail("wready");
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; n = 0;
    while (!bvalid && n < 50) begin tick; n++; end
    if (!bvalid) timeout_fail("bvalid");
    resp = bresp;
    tick;
    bready = 1'b0;
  endtask

  // mode 0: rready always high; 1: 1,0,1,0...; 2: random
  task automatic axi_read(input logic [31:0] addr, input int len, input int mode);
    int n, beats, cyc;
    logic stalled;
    logic [34:0] prev;
    araddr = addr; arlen = 8'(len); arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin tick; n++; end
    if (!arready) timeout_fail("arready");
    tick;
    arvalid = 1'b0;
    check("rvalid one cycle after AR", rvalid, 1'b1);
    beats = 0; cyc = 0; stalled = 1'b0; prev = '0;
    while (beats <= len && cyc < 3000) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (stalled) check("R held during stall", {rvalid, rlast, rresp, rdata}, {1'b1, prev});
      if (rvalid && rready) begin
        rd_data[beats] = rdata; rd_resp[beats] = rresp; rd_last[beats] = rlast;
        beats++;
      end
      stalled = rvalid && !rready;
      prev = {rlast, rresp, rdata};
      tick;
      cyc++;
    end
    rready = 1'b0;
    if (beats <= len) timeout_fail("read beats");
    check("rvalid low after last beat", rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    wvec_t       vecs [7];
    logic [1:0]  resp, expr;
    logic [31:0] v, old;
    int          n;

    vecs[0] = '{BASE + 32'h00,   3,   4'hF,    -1, 2'b00};
    vecs[1] = '{BASE + 32'h20,   0,   4'hF,    -1, 2'b00};
    vecs[2] = '{BASE + 32'h30,   1,   4'b0011, -1, 2'b00};
    vecs[3] = '{BASE + 4*60,     7,   4'hF,    -1, 2'b10};
    vecs[4] = '{BASE + 32'h10,   2,   4'hF,     1, 2'b10};
    vecs[5] = '{BASE + 32'h50,   0,   4'b1000,  0, 2'b10};
    vecs[6] = '{BASE,            255, 4'hF,    -1, 2'b10};

    rst = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 0; wdata = '0; wstrb = '0; wlast = 0; wvalid = 0;
    bready = 0; araddr = '0; arlen = '0; arvalid = 0; rready = 0;
    bd_we = 0; bd_addr = BASE; bd_wdata = '0; bd_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset values
    check("reset awready", awready, 0);
    check("reset arready", arready, 0);
    check("reset wready",  wready,  0);
    check("reset bvalid",  bvalid,  0);
    check("reset rvalid",  rvalid,  0);
    check("reset rlast",   rlast,   0);
    check("reset bresp",   bresp,   0);
    check("reset rresp",   rresp,   0);
    check("reset rdata",   rdata,   0);
    check("reset bd_rdata", bd_rdata, 0);
    rst = 1'b1;
    tick;
    check("awready after release", awready, 1);
    check("arready after release", arready, 1);

    // preload whole memory through the backdoor
    for (int w = 0; w < MW; w++) bd_write(BASE + 32'(4*w), $urandom, 4'hF);
    bd_read(BASE + 32'h14, v);
    check("bd read preload", v, ref_mem[5]);

    // backdoor preload then single-beat read
    bd_write(BASE + 32'h40, 32'hDEAD_BEEF, 4'hF);
    axi_read(BASE + 32'h40, 0, 0);
    check("preload read rdata", rd_data[0], 32'hDEAD_BEEF);
    check("preload read rlast", rd_last[0], 1);
    check("preload read rresp", rd_resp[0], 2'b00);

    // 4-beat write of 1..4, read back with rready toggling
    for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
    axi_write(BASE, 3, 4'hF, -1, resp);
    void'(model_write(BASE, 3, 4'hF, -1));
    check("burst4 bresp", resp, 2'b00);
    axi_read(BASE, 3, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("burst4 beat%0d data", k), rd_data[k], 32'(k + 1));
      check($sformatf("burst4 beat%0d last", k), rd_last[k], k == 3);
    end

    // byte strobes over an all-ones word
    bd_write(BASE + 32'h80, 32'hFFFF_FFFF, 4'hF);
    wbuf[0] = 32'hAABB_CCDD;
    axi_write(BASE + 32'h80, 0, 4'b0101, -1, resp);
    void'(model_write(BASE + 32'h80, 0, 4'b0101, -1));
    bd_read(BASE + 32'h80, v);
    check("strobe merge", v, 32'hFFBB_FFDD);

    // early wlast: both beats written, SLVERR; read past the end
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    axi_write(BASE + 32'h90, 1, 4'hF, 0, resp);
    void'(model_write(BASE + 32'h90, 1, 4'hF, 0));
    check("early wlast bresp", resp, 2'b10);
    axi_read(BASE + 32'h90, 1, 2);
    compare_read("early wlast readback", BASE + 32'h90, 1);
    axi_read(BASE + 4*MW, 0, 0);
    check("oob read rdata", rd_data[0], 32'hFFFF_FFFF);
    check("oob read rresp", rd_resp[0], 2'b10);

    // table of write bursts, each read back through the model
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k <= int'(vecs[i].len); k++) wbuf[k] = $urandom;
      axi_write(vecs[i].addr, int'(vecs[i].len), vecs[i].strb, vecs[i].bad_last, resp);
      void'(model_write(vecs[i].addr, int'(vecs[i].len), vecs[i].strb, vecs[i].bad_last));
      check($sformatf("vec%0d bresp", i), resp, vecs[i].exp_bresp);
      axi_read(vecs[i].addr, int'(vecs[i].len), 2);
      compare_read($sformatf("vec%0d", i), vecs[i].addr, int'(vecs[i].len));
    end

    // AXI write, backdoor write and AXI read of the same word in one cycle
    old = ref_mem[40];
    awaddr = BASE + 32'hA0; awlen = 8'd0; awvalid = 1'b1; n = 0;
    while (!awready && n < 50) begin tick; n++; end
    tick;
    awvalid = 1'b0;
    wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; n = 0;
    while (!wready && n < 50) begin tick; n++; end
    if (!wready) timeout_fail("collision wready");
    check("collision arready", arready, 1);
    araddr = BASE + 32'hA0; arlen = 8'd0; arvalid = 1'b1;
    bd_we = 1'b1; bd_addr = BASE + 32'hA0; bd_wdata = 32'h8765_4321; bd_wstrb = 4'hF;
    tick;
    bd_we = 1'b0; wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    ref_mem[40] = 32'h1234_5678;
    check("same-cycle read rvalid", rvalid, 1);
    check("same-cycle read old data", rdata, old);
    check("collision bvalid", bvalid, 1);
    check("collision bresp", bresp, 2'b00);
    rready = 1'b1; bready = 1'b1;
    tick;
    rready = 1'b0; bready = 1'b0;
    bd_read(BASE + 32'hA0, v);
    check("AXI wins over backdoor", v, 32'h1234_5678);

    // random bursts against the model
    for (int i = 0; i < 25; i++) begin
      logic [31:0] a = BASE + 32'(4 * $urandom_range(0, MW + 4));
      int          l = $urandom_range(0, 9);
      logic [3:0]  s = 4'($urandom_range(0, 15));
      int          bl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, l) : -1;
      for (int k = 0; k <= l; k++) wbuf[k] = $urandom;
      axi_write(a, l, s, bl, resp);
      expr = model_write(a, l, s, bl);
      check($sformatf("rand%0d bresp", i), resp, expr);
      axi_read(a, l, 2);
      compare_read($sformatf("rand%0d wr-readback", i), a, l);
      a = BASE + 32'(4 * $urandom_range(0, MW + 2));
      l = $urandom_range(0, 11);
      axi_read(a, l, 2);
      compare_read($sformatf("rand%0d read", i), a, l);
    end

    // reset asserted while beat 2 of a 4-beat read is on the bus
    araddr = BASE; arlen = 8'd3; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin tick; n++; end
    tick;
    arvalid = 1'b0; rready = 1'b1;
    tick;
    tick;
    rready = 1'b0;
    check("beat2 before reset", {rvalid, rdata}, {1'b1, ref_mem[2]});
    rst = 1'b0;
    #1;
    check("abort rvalid", rvalid, 0);
    check("abort rlast",  rlast,  0);
    check("abort rdata",  rdata,  0);
    check("abort arready", arready, 0);
    tick;
    tick;
    check("bd_rdata in reset", bd_rdata, 0);
    rst = 1'b1;
    tick;
    check("arready after abort", arready, 1);
    check("awready after abort", awready, 1);
    for (int w = 0; w < 8; w++) begin
      bd_read(BASE + 32'(4*w), v);
      check($sformatf("intact word%0d", w), v, ref_mem[w]);
    end
    axi_read(BASE, 3, 0);
    compare_read("read after abort", BASE, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
